bus_resp: RTL and testbench

Bus response and error generator for the CPU-side system bus. It sits between the address decoder's chipselect/fault outputs and the per-device slaves. It routes the strobe to the selected slave and returns that slave's ack and read data to the master. It terminates undecoded accesses and hung slaves with a bus error, capturing the failing address for software.

---
 rtl/bus_resp.sv | 151 +++++++++++++++
 tb/tb_bus_resp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_resp.sv
// Bus response/error generator: routes the master strobe to the decoded slave,
// returns ack/data, and terminates undecoded or hung accesses with a bus error.
module bus_resp #(
  parameter int NSLAVE  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic [31:0]          adr_i,
  input  logic [3:0]           chipselect,
  input  logic                 fault,
  input  logic [NSLAVE-1:0]    s_ack_i,
  input  logic [32*NSLAVE-1:0] s_dat_i,
  output logic [NSLAVE-1:0]    s_stb_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic [31:0]          dat_o,
  output logic                 fault_flag_o,
  output logic                 fault_cause_o,
  output logic [31:0]          fault_adr_o,
  input  logic                 fault_clr_i
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]      NS       = 5'(NSLAVE);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       adr_q, adr_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       dat_q, dat_d;
  logic              flag_q, flag_d;
  logic              cause_q, cause_d;
  logic [31:0]       fadr_q, fadr_d;

  logic              ack_sel;
  logic [31:0]       dat_sel;
  logic [NSLAVE-1:0] stb;
  logic              bad_req;
  logic              new_err;

  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    stb     = '0;
    for (int k = 0; k < NSLAVE; k++) begin
      if (sel_q == 4'(k)) begin
        ack_sel = s_ack_i[k];
        dat_sel = s_dat_i[32*k +: 32];
        stb[k]  = (state_q == WAIT);
      end
    end

    bad_req = fault || (chipselect == 4'd0) || ({1'b0, chipselect} >= NS);

    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    cause_d = cause_q;
    fadr_d  = fadr_q;
    new_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          if (bad_req) begin
            state_d = ERR;
            err_d   = 1'b1;
            fadr_d  = adr_i;
            cause_d = 1'b0;
            new_err = 1'b1;
          end else begin
            state_d = WAIT;
            sel_d   = chipselect;
            cnt_d   = '0;
            adr_d   = adr_i;
          end
        end
      end
      WAIT: begin
        // A master abort takes precedence; ack beats the timeout limit.
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (ack_sel) begin
          state_d = DONE;
          ack_d   = 1'b1;
          dat_d   = dat_sel;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
          fadr_d  = adr_q;
          cause_d = 1'b1;
          new_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    flag_d = new_err ? 1'b1 : (fault_clr_i ? 1'b0 : flag_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      adr_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      flag_q  <= 1'b0;
      cause_q <= 1'b0;
      fadr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      flag_q  <= flag_d;
      cause_q <= cause_d;
      fadr_q  <= fadr_d;
    end
  end

  assign s_stb_o       = stb;
  assign ack_o         = ack_q;
  assign err_o         = err_q;
  assign dat_o         = dat_q;
  assign fault_flag_o  = flag_q;
  assign fault_cause_o = cause_q;
  assign fault_adr_o   = fadr_q;

endmodule

// File: tb/tb_bus_resp.sv
// Directed bench for bus_resp: responses are predicted into a queue when stimulus
// is driven and compared (value and cycle) when ack_o/err_o appear.
module tb_bus_resp;
  localparam int NSLAVE  = 10;
  localparam int TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 rst_i, cyc_i, stb_i, fault, fault_clr_i;
  logic [31:0]          adr_i;
  logic [3:0]           chipselect;
  logic [NSLAVE-1:0]    s_ack_i;
  logic [32*NSLAVE-1:0] s_dat_i;
  logic [NSLAVE-1:0]    s_stb_o;
  logic                 ack_o, err_o, fault_flag_o, fault_cause_o;
  logic [31:0]          dat_o, fault_adr_o;

  bus_resp #(.NSLAVE(NSLAVE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .adr_i(adr_i),
    .chipselect(chipselect), .fault(fault), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .s_stb_o(s_stb_o), .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o),
    .fault_flag_o(fault_flag_o), .fault_cause_o(fault_cause_o),
    .fault_adr_o(fault_adr_o), .fault_clr_i(fault_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        cause;
    logic [31:0] adr;
    logic        flag;
  } exp_t;

  exp_t        sb[$];
  int          nchecks = 0;
  int          nerr    = 0;
  int          cyc_n   = 0;
  int          e_cyc;
  logic [31:0] m_dat   = '0;
  logic [31:0] m_adr   = '0;
  logic        m_cause = 1'b0;
  logic        m_flag  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic push_exp(input int c, input bit is_err, input logic [31:0] dat,
                          input logic cause, input logic [31:0] adr);
    exp_t e;
    if (is_err) begin
      m_cause = cause;
      m_adr   = adr;
      m_flag  = 1'b1;
    end else begin
      m_dat = dat;
    end
    e.cyc = c; e.ack = !is_err; e.err = is_err; e.dat = m_dat;
    e.cause = m_cause; e.adr = m_adr; e.flag = m_flag;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc_n++;
    #1;
    if (ack_o || err_o) begin
      nchecks++;
      assert (sb.size() != 0) else begin
        nerr++;
        $error("FAIL unexpected_resp: observed ack=%0b err=%0b at cycle %0d, required none",
               ack_o, err_o, cyc_n);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_cycle", cyc_n, e.cyc);
        chk("ack_o", ack_o, e.ack);
        chk("err_o", err_o, e.err);
        chk("dat_o", dat_o, e.dat);
        chk("fault_cause_o", fault_cause_o, e.cause);
        chk("fault_adr_o", fault_adr_o, e.adr);
        chk("fault_flag_o", fault_flag_o, e.flag);
      end
    end else if (sb.size() != 0) begin
      if (cyc_n >= sb[0].cyc) begin
        nchecks++;
        assert (cyc_n < sb[0].cyc) else begin
          nerr++;
          $error("FAIL missing_resp: observed none at cycle %0d, required response at %0d",
                 cyc_n, sb[0].cyc);
        end
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic req(input logic [3:0] cs, input logic [31:0] adr);
    cyc_i = 1'b1; stb_i = 1'b1; fault = 1'b0; chipselect = cs; adr_i = adr;
  endtask

  task automatic idle_in();
    cyc_i = 1'b0; stb_i = 1'b0; fault = 1'b0; s_ack_i = '0; fault_clr_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stb"}, 32'(s_stb_o), 32'h0);
    chk({tag, "_ack"}, 32'(ack_o), 32'h0);
    chk({tag, "_err"}, 32'(err_o), 32'h0);
    chk({tag, "_dat"}, dat_o, 32'h0);
    chk({tag, "_flag"}, 32'(fault_flag_o), 32'h0);
    chk({tag, "_cause"}, 32'(fault_cause_o), 32'h0);
    chk({tag, "_adr"}, fault_adr_o, 32'h0);
  endtask

  initial begin
    s_dat_i = '0; s_ack_i = '0; fault = 1'b0; fault_clr_i = 1'b0;
    rst_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; chipselect = 4'd6; adr_i = 32'hDEAD0000;
    tick(); tick();
    chk_all_zero("reset");
    rst_i = 1'b0; idle_in();
    tick();
    chk("idle_stb", 32'(s_stb_o), 32'h0);

    // normal read, slave 6 acks in the first WAIT cycle
    req(4'd6, 32'h1000_0060);
    tick();
    chk("rd_stb", 32'(s_stb_o), 32'h040);
    s_ack_i = 10'h040; s_dat_i[32*6 +: 32] = 32'hDEADBEEF;
    push_exp(cyc_n + 1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0);
    tick();
    chk("done_stb", 32'(s_stb_o), 32'h0);
    idle_in(); tick();

    // decode fault
    req(4'd2, 32'h0100_0000); fault = 1'b1;
    push_exp(cyc_n + 1, 1'b1, 32'h0, 1'b0, 32'h0100_0000);
    tick();
    chk("dec_stb", 32'(s_stb_o), 32'h0);
    idle_in(); tick();
    chk("dec_flag_sticky", 32'(fault_flag_o), 32'h1);
    fault_clr_i = 1'b1; m_flag = 1'b0;
    tick();
    fault_clr_i = 1'b0;
    chk("clr_flag", 32'(fault_flag_o), 32'h0);

    // timeout: address is taken from accept time, not the live bus
    req(4'd3, 32'hD000_0010);
    tick();
    e_cyc = cyc_n;
    adr_i = 32'hFFFF_FFFF;
    push_exp(e_cyc + TIMEOUT, 1'b1, 32'h0, 1'b1, 32'hD000_0010);
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_stb", 32'(s_stb_o), 32'h008);
      tick();
    end
    idle_in();
    chk("to_err_stb", 32'(s_stb_o), 32'h0);
    tick();
    fault_clr_i = 1'b1; m_flag = 1'b0;
    tick();
    fault_clr_i = 1'b0;

    // ack exactly at the limit wins; foreign acks beforehand are ignored
    req(4'd9, 32'h9000_0000);
    tick();
    chk("lim_stb", 32'(s_stb_o), 32'h200);
    s_ack_i = 10'h1FF;
    for (int k = 0; k < NSLAVE; k++) s_dat_i[32*k +: 32] = 32'hBAD0_0000 + 32'(k);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    s_ack_i = 10'h200; s_dat_i[32*9 +: 32] = 32'h1234_5678;
    push_exp(cyc_n + 1, 1'b0, 32'h1234_5678, 1'b0, 32'h0);
    tick();
    idle_in(); tick();

    // clear racing a new decode fault (chipselect 0): flag must stay set
    req(4'd0, 32'h0000_0004); fault_clr_i = 1'b1;
    push_exp(cyc_n + 1, 1'b1, 32'h0, 1'b0, 32'h0000_0004);
    tick();
    idle_in(); tick();
    chk("race_flag", 32'(fault_flag_o), 32'h1);

    // chipselect beyond the last slave
    req(4'd10, 32'hA000_0000);
    push_exp(cyc_n + 1, 1'b1, 32'h0, 1'b0, 32'hA000_0000);
    tick();
    chk("oor_stb", 32'(s_stb_o), 32'h0);
    idle_in(); tick();

    // abort in the third WAIT cycle, late ack ignored, next access served
    req(4'd4, 32'h4000_0000);
    tick(); tick(); tick();
    chk("ab_stb", 32'(s_stb_o), 32'h010);
    cyc_i = 1'b0; stb_i = 1'b0;
    tick();
    chk("ab_idle_stb", 32'(s_stb_o), 32'h0);
    s_ack_i = 10'h010; s_dat_i[32*4 +: 32] = 32'h5555_AAAA;
    tick(); tick();
    chk("ab_late_dat", dat_o, m_dat);
    chk("ab_flag", 32'(fault_flag_o), 32'h1);
    s_ack_i = '0;
    req(4'd4, 32'h4000_0004);
    tick();
    chk("ab_next_stb", 32'(s_stb_o), 32'h010);
    tick();
    s_ack_i = 10'h010; s_dat_i[32*4 +: 32] = 32'hCAFE_F00D;
    push_exp(cyc_n + 1, 1'b0, 32'hCAFE_F00D, 1'b0, 32'h0);
    tick();
    idle_in(); tick();

    // reset mid-transaction
    req(4'd5, 32'h5000_0000);
    tick();
    chk("mid_stb", 32'(s_stb_o), 32'h020);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; idle_in();
    m_dat = '0; m_adr = '0; m_cause = 1'b0; m_flag = 1'b0;
    chk_all_zero("mid_rst");
    tick();
    chk("mid_idle_stb", 32'(s_stb_o), 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
